// File: rtl/cg_tlb_fully_associative.sv
// Fully-associative Sv39-style TLB with one outstanding miss to a page-table walker.
// Hits return {PPN, offset} one cycle after the lookup; misses raise o_tlb_miss
// until the PTW refill arrives, then install the entry round-robin and return it.
// Optional macro CG_TLB_ASID_EN: when defined, entries carry an ASID and a hit also
// needs the ASID to match; when undefined, i_asid is ignored and no ASID is stored.
//
// Handshake: i_vaddr_valid is a one-cycle request sampled only in IDLE;
// o_paddr_valid is a one-cycle pulse per translation; o_tlb_miss is a level held
// until the cycle after i_ptw_valid, which is honoured only while a miss is pending.
module cg_tlb_fully_associative #(
    parameter int VADDR_WIDTH = 39,
    parameter int PADDR_WIDTH = 56,
    parameter int ASID_WIDTH  = 16,
    parameter int ENTRIES     = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_vaddr_valid,
    input  logic [VADDR_WIDTH-1:0] i_vaddr,
    input  logic [ASID_WIDTH-1:0]  i_asid,
    output logic                   o_paddr_valid,
    output logic [PADDR_WIDTH-1:0] o_paddr,
    output logic                   o_tlb_miss,
    output logic [VADDR_WIDTH-1:0] o_tlb_miss_vaddr,
    input  logic                   i_ptw_valid,
    input  logic [PADDR_WIDTH-1:0] i_ptw_paddr,
    output logic                   o_dbg_state
);

    localparam int VPN_W = VADDR_WIDTH - 12;
    localparam int PPN_W = PADDR_WIDTH - 12;
    localparam int PTR_W = $clog2(ENTRIES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   repl_ptr;
    logic [ENTRIES-1:0] ent_valid;
    logic [VPN_W-1:0]   ent_vpn [ENTRIES];
    logic [PPN_W-1:0]   ent_ppn [ENTRIES];
`ifdef CG_TLB_ASID_EN
    logic [ASID_WIDTH-1:0] ent_asid [ENTRIES];
    logic [ASID_WIDTH-1:0] miss_asid;
`endif

    logic [ENTRIES-1:0] match;
    logic               hit;
    logic [PPN_W-1:0]   hit_ppn;
    logic               unused_bits;

    // Page offset of the PTW address is replaced by the request's own offset.
`ifdef CG_TLB_ASID_EN
    assign unused_bits = ^i_ptw_paddr[11:0];
`else
    assign unused_bits = ^{i_asid, i_ptw_paddr[11:0]};
`endif

    assign o_dbg_state = state;

    // Parallel tag compare of the request against every valid entry.
    always_comb begin
        match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
`ifdef CG_TLB_ASID_EN
            match[i] = ent_valid[i] && (ent_vpn[i] == i_vaddr[VADDR_WIDTH-1:12])
                       && (ent_asid[i] == i_asid);
`else
            match[i] = ent_valid[i] && (ent_vpn[i] == i_vaddr[VADDR_WIDTH-1:12]);
`endif
        end
    end

    // Select the matching PPN; scanning downwards lets the lowest index win.
    always_comb begin
        hit     = 1'b0;
        hit_ppn = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_ppn = ent_ppn[i];
            end
        end
    end

    // Lookup/refill FSM, entry storage and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= S_IDLE;
            repl_ptr         <= '0;
            ent_valid        <= '0;
            o_paddr_valid    <= 1'b0;
            o_paddr          <= '0;
            o_tlb_miss       <= 1'b0;
            o_tlb_miss_vaddr <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_vpn[i] <= '0;
                ent_ppn[i] <= '0;
`ifdef CG_TLB_ASID_EN
                ent_asid[i] <= '0;
`endif
            end
`ifdef CG_TLB_ASID_EN
            miss_asid <= '0;
`endif
        end else begin
            o_paddr_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_vaddr_valid) begin
                        if (hit) begin
                            o_paddr_valid <= 1'b1;
                            o_paddr       <= {hit_ppn, i_vaddr[11:0]};
                        end else begin
                            o_tlb_miss       <= 1'b1;
                            o_tlb_miss_vaddr <= i_vaddr;
`ifdef CG_TLB_ASID_EN
                            miss_asid        <= i_asid;
`endif
                            state            <= S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    if (i_ptw_valid) begin
                        ent_valid[repl_ptr] <= 1'b1;
                        ent_vpn[repl_ptr]   <= o_tlb_miss_vaddr[VADDR_WIDTH-1:12];
                        ent_ppn[repl_ptr]   <= i_ptw_paddr[PADDR_WIDTH-1:12];
`ifdef CG_TLB_ASID_EN
                        ent_asid[repl_ptr]  <= miss_asid;
`endif
                        // Power-of-two depth makes the natural wrap round-robin.
                        repl_ptr      <= repl_ptr + 1'b1;
                        o_paddr_valid <= 1'b1;
                        o_paddr       <= {i_ptw_paddr[PADDR_WIDTH-1:12], o_tlb_miss_vaddr[11:0]};
                        o_tlb_miss    <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cg_tlb_fully_associative.sv
// Directed bench for cg_tlb_fully_associative: drivers push expected translations
// and expected miss addresses into queues; a negedge monitor pops and compares
// whenever the DUT pulses o_paddr_valid or raises o_tlb_miss.
module tb_cg_tlb_fully_associative;

    localparam int VW = 39;
    localparam int PW = 56;
    localparam int AW = 16;
    localparam int ENTRIES = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_vaddr_valid = 1'b0;
    logic [VW-1:0] i_vaddr = '0;
    logic [AW-1:0] i_asid = '0;
    logic          o_paddr_valid;
    logic [PW-1:0] o_paddr;
    logic          o_tlb_miss;
    logic [VW-1:0] o_tlb_miss_vaddr;
    logic          i_ptw_valid = 1'b0;
    logic [PW-1:0] i_ptw_paddr = '0;
    logic          o_dbg_state;

    logic [PW-1:0] exp_q[$];
    logic [VW-1:0] miss_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    bit            miss_prev = 1'b0;
    logic [PW-1:0] exp_pa;
    logic [VW-1:0] exp_va;

    localparam logic [VW-1:0] COLD_VA  = 39'h0be_efca_fe14;
    localparam logic [VW-1:0] COLD_VA0 = 39'h0be_efca_f000;
    localparam logic [PW-1:0] COLD_PTW = 56'hca_feca_5151_8000;
    localparam logic [PW-1:0] COLD_PA  = 56'hca_feca_5151_8e14;
    localparam logic [PW-1:0] COLD_PA0 = 56'hca_feca_5151_8000;
    localparam logic [VW-1:0] A_VA     = 39'h00_1234_5678;
    localparam logic [PW-1:0] A_PTW1   = 56'h00_0000_0abc_d000;
    localparam logic [PW-1:0] A_PA1    = 56'h00_0000_0abc_d678;
    localparam logic [PW-1:0] A_PTW3   = 56'h11_2222_3333_4000;
    localparam logic [PW-1:0] A_PA3    = 56'h11_2222_3333_4678;
    localparam logic [VW-1:0] B_VA     = 39'h7f_ffff_f00c;

    cg_tlb_fully_associative #(
        .VADDR_WIDTH(VW), .PADDR_WIDTH(PW), .ASID_WIDTH(AW), .ENTRIES(ENTRIES)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_vaddr_valid   (i_vaddr_valid),
        .i_vaddr         (i_vaddr),
        .i_asid          (i_asid),
        .o_paddr_valid   (o_paddr_valid),
        .o_paddr         (o_paddr),
        .o_tlb_miss      (o_tlb_miss),
        .o_tlb_miss_vaddr(o_tlb_miss_vaddr),
        .i_ptw_valid     (i_ptw_valid),
        .i_ptw_paddr     (i_ptw_paddr),
        .o_dbg_state     (o_dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Wrap-test address table: VPN 0x100+i, offset 0x123, PPN 0xa0000+i.
    function automatic logic [VW-1:0] wrap_va(input int i);
        wrap_va = {27'(27'h100 + i), 12'h123};
    endfunction
    function automatic logic [PW-1:0] wrap_ptw(input int i);
        wrap_ptw = {44'(44'ha0000 + i), 12'h000};
    endfunction
    function automatic logic [PW-1:0] wrap_pa(input int i);
        wrap_pa = {44'(44'ha0000 + i), 12'h123};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            miss_prev = 1'b0;
        end else begin
            if (o_paddr_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_paddr_valid: got %h, expected no translation", o_paddr);
                end else begin
                    exp_pa = exp_q.pop_front();
                    check("paddr", 64'(o_paddr), 64'(exp_pa));
                end
            end
            if (o_tlb_miss && !miss_prev) begin
                if (miss_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_miss: got vaddr %h, expected no miss", o_tlb_miss_vaddr);
                end else begin
                    exp_va = miss_q.pop_front();
                    check("miss_vaddr", 64'(o_tlb_miss_vaddr), 64'(exp_va));
                end
            end
            miss_prev = o_tlb_miss;
        end
    end

    // Driver tasks: all start and end 1 time unit after a rising edge.
    task automatic issue_hit(input logic [VW-1:0] va, input logic [AW-1:0] asid,
                             input logic [PW-1:0] exp);
        exp_q.push_back(exp);
        i_vaddr_valid = 1'b1;
        i_vaddr       = va;
        i_asid        = asid;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        i_vaddr_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_miss(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = o_tlb_miss;
        end
        check("miss_raised", 64'(seen), 64'd1);
    endtask

    // Request held valid through the whole miss; it must be ignored until refill.
    task automatic miss_refill(input logic [VW-1:0] va, input logic [AW-1:0] asid,
                               input logic [PW-1:0] ptw_pa, input logic [PW-1:0] exp,
                               input int hold);
        bit seen;
        miss_q.push_back(va);
        exp_q.push_back(exp);
        i_vaddr_valid = 1'b1;
        i_vaddr       = va;
        i_asid        = asid;
        wait_miss(seen);
        if (seen) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check("miss_held", 64'({o_tlb_miss, o_paddr_valid, o_tlb_miss_vaddr}),
                      64'({1'b1, 1'b0, va}));
            end
            @(posedge clk);
            #1;
            i_ptw_valid = 1'b1;
            i_ptw_paddr = ptw_pa;
            @(posedge clk);
            #1;
            i_ptw_valid = 1'b0;
            i_ptw_paddr = '0;
            check("miss_cleared", 64'({o_tlb_miss, o_dbg_state}), 64'd0);
        end
        i_vaddr_valid = 1'b0;
    endtask

    initial begin
        bit seen;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_paddr_valid", 64'(o_paddr_valid), 64'd0);
        check("rst_paddr", 64'(o_paddr), 64'd0);
        check("rst_miss", 64'(o_tlb_miss), 64'd0);
        check("rst_miss_vaddr", 64'(o_tlb_miss_vaddr), 64'd0);
        check("rst_state", 64'(o_dbg_state), 64'd0);
        rst = 1'b0;
        idle_cycle();

        // Cold miss held 10 cycles, refill, then back-to-back hits
        miss_refill(COLD_VA, 16'h0001, COLD_PTW, COLD_PA, 10);
        for (int k = 0; k < 4; k++) issue_hit(COLD_VA, 16'h0001, COLD_PA);
        issue_hit(COLD_VA0, 16'h0001, COLD_PA0);
        idle_cycle();

        // Fill ENTRIES more VPNs; the cold entry is evicted by the wrap
        for (int i = 0; i < ENTRIES; i++) miss_refill(wrap_va(i), 16'h0001, wrap_ptw(i), wrap_pa(i), 0);
        for (int i = 0; i < ENTRIES; i++) issue_hit(wrap_va(i), 16'h0001, wrap_pa(i));
        idle_cycle();
        miss_refill(COLD_VA, 16'h0001, COLD_PTW, COLD_PA, 0);
        miss_refill(wrap_va(0), 16'h0001, wrap_ptw(0), wrap_pa(0), 0);
        idle_cycle();

        // Spurious PTW strobe in IDLE: no output, no overwrite of the next victim
        i_ptw_valid = 1'b1;
        i_ptw_paddr = 56'hde_adbe_efde_a000;
        @(posedge clk);
        #1;
        i_ptw_valid = 1'b0;
        i_ptw_paddr = '0;
        check("spurious_idle", 64'({o_paddr_valid, o_tlb_miss, o_dbg_state}), 64'd0);
        issue_hit(wrap_va(2), 16'h0001, wrap_pa(2));
        idle_cycle();

        // ASID: same VPN under another ASID
        miss_refill(A_VA, 16'h0001, A_PTW1, A_PA1, 0);
`ifdef CG_TLB_ASID_EN
        miss_refill(A_VA, 16'h0002, 56'h00_0000_0777_7000, 56'h00_0000_0777_7678, 0);
`else
        issue_hit(A_VA, 16'h0002, A_PA1);
`endif
        issue_hit(A_VA, 16'h0001, A_PA1);
        idle_cycle();

        // Reset while a miss is outstanding
        miss_q.push_back(B_VA);
        i_vaddr_valid = 1'b1;
        i_vaddr       = B_VA;
        i_asid        = 16'h0001;
        wait_miss(seen);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_drops_miss", 64'({o_tlb_miss, o_paddr_valid, o_dbg_state}), 64'd0);
        check("rst_clears_miss_vaddr", 64'(o_tlb_miss_vaddr), 64'd0);
        i_vaddr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycle();
        miss_refill(A_VA, 16'h0001, A_PTW3, A_PA3, 0);
        issue_hit(A_VA, 16'h0001, A_PA3);
        idle_cycle();
        idle_cycle();

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("miss_q_drained", 64'(miss_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
